// File: rtl/ping_pkg.sv
// Shared definitions for the ping_array range-finder controller:
// FSM state encoding, 25 MHz default timing and BCD helpers.
package ping_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_W       = 3 * BCD_DIGIT_W;

  localparam int DEF_CHANNELS       = 4;
  localparam int DEF_PRE_CYCLES     = 50;
  localparam int DEF_TRIG_CYCLES    = 250;
  localparam int DEF_CM_CYCLES      = 1450;
  localparam int DEF_TIMEOUT_CYCLES = 250000;
  localparam int DEF_HOLDOFF_CYCLES = 1500000;
  localparam int DEF_MAX_CM         = 500;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_TRIG,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_MEASURE,
    ST_RESULT,
    ST_HOLDOFF
  } ping_state_e;

  // Binary 0..999 to packed hundreds/tens/units nibbles.
  function automatic logic [BCD_W-1:0] to_bcd3(input int v);
    return {BCD_DIGIT_W'((v / 100) % 10),
            BCD_DIGIT_W'((v / 10) % 10),
            BCD_DIGIT_W'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD up-counter with synchronous clear and enable that
// sticks once it reaches LIMIT (0..999).
module bcd_counter3
  import ping_pkg::*;
#(
  parameter int LIMIT = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [BCD_W-1:0] LIMIT_BCD = to_bcd3(LIMIT);

  logic at_limit;
  assign at_limit = (bcd == LIMIT_BCD);

  // Ripple the decimal carry from units to hundreds, frozen at the limit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bcd <= '0;
    end else if (en && !at_limit) begin
      if (bcd[3:0] != 4'd9) begin
        bcd[3:0] <= bcd[3:0] + 4'd1;
      end else begin
        bcd[3:0] <= 4'd0;
        if (bcd[7:4] != 4'd9) begin
          bcd[7:4] <= bcd[7:4] + 4'd1;
        end else begin
          bcd[7:4]  <= 4'd0;
          bcd[11:8] <= bcd[11:8] + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ping_array.sv
// Round-robin controller for up to 16 HC-SR04-style ultrasonic sensors.
// Triggers each enabled sensor in turn, times its echo and presents the
// distance in cm (binary and BCD) on a valid/ready result register.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | parked; picks next masked channel when enabled
// ST_PRE       | trigger held low to settle the sensor
// ST_TRIG      | trigger pulse high on the selected channel
// ST_WAIT_LOW  | waiting for the echo line to be low
// ST_WAIT_HIGH | waiting for the echo to start; clears distance counters
// ST_MEASURE   | counting echo-high time in centimetre steps
// ST_RESULT    | loading result register, stalls while it is occupied
// ST_HOLDOFF   | quiet time before the next ping
//
// CM_CYCLES must be at least 2: the first echo-high cycle is consumed in
// ST_WAIT_HIGH and the divider reload accounts for it.
module ping_array
  import ping_pkg::*;
#(
  parameter int  CHANNELS       = DEF_CHANNELS,
  parameter int  PRE_CYCLES     = DEF_PRE_CYCLES,
  parameter int  TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int  CM_CYCLES      = DEF_CM_CYCLES,
  parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int  HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int  MAX_CM         = DEF_MAX_CM,
  localparam int CW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] chan_mask,
  input  logic [CHANNELS-1:0] echo,
  output logic [CHANNELS-1:0] trig,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CW-1:0]       res_chan,
  output logic [9:0]          res_cm,
  output logic [BCD_W-1:0]    res_bcd,
  output logic                res_timeout,
  output logic                busy
);

  localparam int TMR_MAX_A = (PRE_CYCLES > TRIG_CYCLES) ? PRE_CYCLES : TRIG_CYCLES;
  localparam int TMR_MAX   = (TMR_MAX_A > HOLDOFF_CYCLES) ? TMR_MAX_A : HOLDOFF_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DIV_W     = $clog2(CM_CYCLES + 1);

  localparam logic [9:0]       MAX_CM_B  = 10'(MAX_CM);
  localparam logic [BCD_W-1:0] MAX_BCD   = to_bcd3(MAX_CM);

  ping_state_e         state;
  logic [CHANNELS-1:0] echo_meta;
  logic [CHANNELS-1:0] echo_sync;
  logic [CW-1:0]       ch;
  logic [CW-1:0]       next_ch;
  logic                next_found;
  logic [TMR_W-1:0]    tmr;
  logic [TO_W-1:0]     to_cnt;
  logic [DIV_W-1:0]    div;
  logic [9:0]          cm_cnt;
  logic                timed_out;
  logic [BCD_W-1:0]    bcd_cnt;
  logic                echo_s;
  logic                to_live;
  logic                div_tc;
  logic                bcd_clr;
  logic                bcd_en;
  int                  idx;

  assign echo_s  = echo_sync[ch];
  assign to_live = (to_cnt != '0);
  assign div_tc  = (div <= DIV_W'(1));
  assign bcd_clr = (state == ST_WAIT_HIGH) && to_live && echo_s;
  assign bcd_en  = (state == ST_MEASURE) && to_live && echo_s && div_tc;

  // Two-flop synchroniser for every raw echo line.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_meta <= '0;
      echo_sync <= '0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  // First masked channel after the last one pinged, wrapping round.
  always_comb begin
    next_ch    = ch;
    next_found = 1'b0;
    idx        = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = int'(ch) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!next_found && chan_mask[CW'(idx)]) begin
        next_ch    = CW'(idx);
        next_found = 1'b1;
      end
    end
  end

  bcd_counter3 #(
    .LIMIT (MAX_CM)
  ) u_bcd (
    .clk   (clk),
    .reset (reset),
    .clear (bcd_clr),
    .en    (bcd_en),
    .bcd   (bcd_cnt)
  );

  // Sequencer, timers and the result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ch          <= CW'(CHANNELS - 1);
      trig        <= '0;
      busy        <= 1'b0;
      tmr         <= '0;
      to_cnt      <= '0;
      div         <= '0;
      cm_cnt      <= '0;
      timed_out   <= 1'b0;
      res_valid   <= 1'b0;
      res_chan    <= '0;
      res_cm      <= '0;
      res_bcd     <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (enable && next_found) begin
            ch    <= next_ch;
            tmr   <= TMR_W'(PRE_CYCLES);
            busy  <= 1'b1;
            state <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (tmr == '0) begin
            trig[ch] <= 1'b1;
            tmr      <= TMR_W'(TRIG_CYCLES - 1);
            state    <= ST_TRIG;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_TRIG: begin
          if (tmr == '0) begin
            trig      <= '0;
            to_cnt    <= TO_W'(TIMEOUT_CYCLES - 1);
            timed_out <= 1'b0;
            state     <= ST_WAIT_LOW;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_WAIT_LOW: begin
          if (!to_live) begin
            timed_out <= 1'b1;
            state     <= ST_RESULT;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
            if (!echo_s) state <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (!to_live) begin
            timed_out <= 1'b1;
            state     <= ST_RESULT;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
            if (echo_s) begin
              cm_cnt <= '0;
              div    <= DIV_W'(CM_CYCLES - 1);
              state  <= ST_MEASURE;
            end
          end
        end
        ST_MEASURE: begin
          if (!to_live) begin
            timed_out <= 1'b1;
            state     <= ST_RESULT;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
            if (!echo_s) begin
              state <= ST_RESULT;
            end else if (div_tc) begin
              div <= DIV_W'(CM_CYCLES);
              if (cm_cnt != MAX_CM_B) cm_cnt <= cm_cnt + 10'd1;
            end else begin
              div <= div - DIV_W'(1);
            end
          end
        end
        ST_RESULT: begin
          if (!res_valid || res_ready) begin
            res_valid   <= 1'b1;
            res_chan    <= ch;
            res_cm      <= timed_out ? MAX_CM_B : cm_cnt;
            res_bcd     <= timed_out ? MAX_BCD : bcd_cnt;
            res_timeout <= timed_out;
            tmr         <= TMR_W'(HOLDOFF_CYCLES - 1);
            state       <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (tmr == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: begin
          trig  <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ping_array.sv
// Scoreboard bench for ping_array with scaled-down timing. A sensor model
// answers each trigger with a random echo and queues the expected result;
// a monitor pops and compares on every accepted result.
module tb_ping_array;
  import ping_pkg::*;

  localparam int CH   = 4;
  localparam int PRE  = 5;
  localparam int TRG  = 10;
  localparam int CM   = 8;
  localparam int TOUT = 1000;
  localparam int HOLD = 30;
  localparam int MAXC = 50;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [CH-1:0] chan_mask;
  logic [CH-1:0] echo;
  logic [CH-1:0] trig;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_chan;
  logic [9:0]    res_cm;
  logic [11:0]   res_bcd;
  logic          res_timeout;
  logic          busy;

  always #5 clk = ~clk;

  ping_array #(
    .CHANNELS       (CH),
    .PRE_CYCLES     (PRE),
    .TRIG_CYCLES    (TRG),
    .CM_CYCLES      (CM),
    .TIMEOUT_CYCLES (TOUT),
    .HOLDOFF_CYCLES (HOLD),
    .MAX_CM         (MAXC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .chan_mask   (chan_mask),
    .echo        (echo),
    .trig        (trig),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_chan    (res_chan),
    .res_cm      (res_cm),
    .res_bcd     (res_bcd),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  typedef struct {
    int chan;
    int cm;
    int tmo;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            exp_last = CH - 1;
  int            ping_done = 0;
  int            ping_idx  = 0;
  logic [CH-1:0] mask_plan = 4'b0101;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
  endtask

  // Decimal digits of v packed as hex nibbles.
  function automatic int ref_bcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Round-robin rule: next set mask bit after the last pinged channel.
  function automatic int next_chan(input int last, input logic [CH-1:0] m);
    for (int k = 1; k <= CH; k++)
      if (m[(last + k) % CH]) return (last + k) % CH;
    return -1;
  endfunction

  // Sensor model: checks each trigger pulse and answers it with an echo.
  initial begin : sensor
    echo      = '0;
    chan_mask = 4'b0101;
    forever begin : one_cycle
      int ch, w, d, n;
      exp_t e;
      @(posedge clk); #1;
      if (reset) begin
        exp_last = CH - 1;
        continue;
      end
      if (trig == '0) continue;
      ch = 0;
      for (int i = 0; i < CH; i++) if (trig[i]) ch = i;
      check("trig_onehot", $countones(trig), 1);
      check("trig_chan", ch, next_chan(exp_last, chan_mask));
      exp_last = ch;
      w = 0;
      while (trig[ch] && !reset && w < 1000) begin
        w++;
        @(posedge clk); #1;
      end
      if (reset) continue;
      check("trig_width", w, TRG);
      chan_mask = mask_plan;
      case (ping_idx)
        0: n = 5 * CM + 7;
        1: n = 37 * CM;
        2: n = 0;
        3: n = 70 * CM;
        4: n = 3;
        default: n = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(60 * CM, 1));
      endcase
      e.chan = ch;
      e.tmo  = (n == 0) ? 1 : 0;
      e.cm   = (n == 0) ? MAXC : (((n / CM) > MAXC) ? MAXC : (n / CM));
      exp_q.push_back(e);
      ping_idx++;
      ping_done++;
      if (n != 0) begin
        d = int'($urandom_range(40, 0));
        repeat (d) begin
          @(posedge clk); #1;
        end
        echo[ch] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        echo[ch] = 1'b0;
      end
    end
  end

  // Monitor: compares accepted results and checks hold stability.
  initial begin : monitor
    logic [24:0] held_val;
    bit          held;
    exp_t        e;
    held = 0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 0;
        exp_q.delete();
        continue;
      end
      check("trig_at_most_one", int'($countones(trig) <= 1), 1);
      if (held && res_valid)
        check("hold_stable", int'({res_chan, res_cm, res_bcd, res_timeout}), int'(held_val));
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(res_chan), -1);
        end else begin
          e = exp_q.pop_front();
          check("res_chan", int'(res_chan), e.chan);
          check("res_cm", int'(res_cm), e.cm);
          check("res_bcd", int'(res_bcd), ref_bcd(e.cm));
          check("res_timeout", int'(res_timeout), e.tmo);
        end
      end
      held     = res_valid && !res_ready;
      held_val = {res_chan, res_cm, res_bcd, res_timeout};
    end
  end

  task automatic wait_pings(input int target, input int budget);
    int c = 0;
    while (ping_done < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (ping_done < target) check("ping_progress_timeout", ping_done, target);
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, start;
    reset     = 1'b1;
    enable    = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_trig", int'(trig), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_chan", int'(res_chan), 0);
    check("rst_res_cm", int'(res_cm), 0);
    check("rst_res_bcd", int'(res_bcd), 0);
    check("rst_res_timeout", int'(res_timeout), 0);
    check("rst_busy", int'(busy), 0);

    // First trigger latency from the first enabled IDLE edge.
    #1 enable = 1'b1;
    lat = 0;
    while (trig == '0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_trig_latency", lat - 1, PRE + 1);

    // Directed pings on channels 0 and 2: distance, timeout, saturation, zero.
    wait_pings(5, 20000);
    wait_drain(5000);

    // Random distances with changing channel masks.
    for (int r = 0; r < 3; r++) begin
      mask_plan = 4'($urandom_range(15, 1));
      wait_pings(ping_done + 3, 20000);
    end
    wait_drain(5000);

    // Back-pressure across two measurements.
    @(posedge clk); #2 res_ready = 1'b0;
    start = ping_done;
    wait_pings(start + 2, 10000);
    repeat (TOUT + 200) @(posedge clk);
    #2;
    check("stall_busy", int'(busy), 1);
    check("stall_res_valid", int'(res_valid), 1);
    check("stall_no_new_ping", ping_done, start + 2);
    check("stall_pending_results", exp_q.size(), 2);
    res_ready = 1'b1;
    wait_drain(5000);
    check("stall_drained", exp_q.size(), 0);

    // Reset in the middle of a trigger pulse.
    mask_plan = 4'b0101;
    wait_pings(ping_done + 1, 10000);
    wait_drain(5000);
    lat = 0;
    while (trig == '0 && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("saw_trig_before_reset", int'(trig != '0), 1);
    check("queue_empty_at_reset", exp_q.size(), 0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("reset_trig_low", int'(trig), 0);
    check("reset_res_valid", int'(res_valid), 0);
    check("reset_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    lat = 0;
    while (trig == '0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("restart_chan0", int'(trig), 1);

    // Dropping enable lets the current measurement finish, then parks.
    start = ping_done;
    wait_pings(start + 1, 5000);
    #2 enable = 1'b0;
    wait_drain(5000);
    repeat (TOUT + HOLD + 100) @(posedge clk);
    #2;
    check("disable_parks_busy", int'(busy), 0);
    check("disable_no_new_ping", ping_done, start + 1);
    check("disable_trig_low", int'(trig), 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
